// File: rtl/main_memory_arbiter_if.sv
// Main-memory port A bundle shared by the two requesters, the arbiter and the memory.
// The slave modport is the arbiter's view. The master modport is the requester/memory side.
interface main_memory_arbiter_if;
  logic        req0_req;
  logic        req0_we;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_gnt;
  logic        req0_rvalid;
  logic [31:0] req0_rdata;
  logic        req0_err;

  logic        req1_req;
  logic        req1_we;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_gnt;
  logic        req1_rvalid;
  logic [31:0] req1_rdata;
  logic        req1_err;

  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0_req, req0_we, req0_addr, req0_wdata,
    output req0_gnt, req0_rvalid, req0_rdata, req0_err,
    input  req1_req, req1_we, req1_addr, req1_wdata,
    output req1_gnt, req1_rvalid, req1_rdata, req1_err,
    output mem_wen, mem_ren, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_req, req0_we, req0_addr, req0_wdata,
    input  req0_gnt, req0_rvalid, req0_rdata, req0_err,
    output req1_req, req1_we, req1_addr, req1_wdata,
    input  req1_gnt, req1_rvalid, req1_rdata, req1_err,
    input  mem_wen, mem_ren, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/main_memory_arbiter.sv
// Two-requester arbiter for main-memory port A.
// It issues one registered single-cycle command per grant and sends back a one-cycle response for reads and out-of-range accesses.
module main_memory_arbiter #(
  parameter logic [31:0] MEMORY_SIZE = 32'h0000_0083,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input logic clk,
  input logic rst_n,
  main_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q;
  logic        last_gnt_q, win_q, we_q, oor_q;
  logic        req0_gnt_q, req1_gnt_q, req0_rvalid_q, req1_rvalid_q, req0_err_q, req1_err_q;
  logic [31:0] req0_rdata_q, req1_rdata_q;
  logic        mem_wen_q, mem_ren_q;
  logic [31:0] mem_addr_q, mem_wdata_q;

  logic        any_d, win_d, sel_we_d, in_range_d;
  logic [31:0] sel_addr_d, sel_wdata_d;

  // Pick the winner: contention goes to the requester not granted last, unless priority is fixed
  always_comb begin
    any_d = bus.req0_req | bus.req1_req;
    win_d = 1'b0;
    if (bus.req0_req && bus.req1_req) begin
      if (FIXED_PRIO != 1'b0) begin
        win_d = 1'b0;
      end else begin
        win_d = ~last_gnt_q;
      end
    end else if (bus.req1_req) begin
      win_d = 1'b1;
    end else begin
      win_d = 1'b0;
    end
    sel_we_d    = win_d ? bus.req1_we    : bus.req0_we;
    sel_addr_d  = win_d ? bus.req1_addr  : bus.req0_addr;
    sel_wdata_d = win_d ? bus.req1_wdata : bus.req0_wdata;
    in_range_d  = (sel_addr_d < MEMORY_SIZE);
  end

  // Arbitration FSM with registered handshake, response and memory-command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_gnt_q    <= 1'b1;
      win_q         <= 1'b0;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      req0_gnt_q    <= 1'b0;
      req1_gnt_q    <= 1'b0;
      req0_rvalid_q <= 1'b0;
      req1_rvalid_q <= 1'b0;
      req0_err_q    <= 1'b0;
      req1_err_q    <= 1'b0;
      req0_rdata_q  <= 32'h0000_0000;
      req1_rdata_q  <= 32'h0000_0000;
      mem_wen_q     <= 1'b0;
      mem_ren_q     <= 1'b0;
      mem_addr_q    <= 32'h0000_0000;
      mem_wdata_q   <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          req0_rvalid_q <= 1'b0;
          req1_rvalid_q <= 1'b0;
          req0_err_q    <= 1'b0;
          req1_err_q    <= 1'b0;
          if (any_d) begin
            state_q     <= ISSUE;
            win_q       <= win_d;
            we_q        <= sel_we_d;
            oor_q       <= ~in_range_d;
            last_gnt_q  <= win_d;
            req0_gnt_q  <= ~win_d;
            req1_gnt_q  <= win_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            mem_ren_q   <= in_range_d & ~sel_we_d;
            mem_wen_q   <= in_range_d & sel_we_d;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          req0_gnt_q <= 1'b0;
          req1_gnt_q <= 1'b0;
          mem_ren_q  <= 1'b0;
          mem_wen_q  <= 1'b0;
          // In-range writes complete silently; everything else gets a response
          if (!we_q || oor_q) begin
            state_q <= RESP;
            if (win_q) begin
              req1_rvalid_q <= 1'b1;
              req1_err_q    <= oor_q;
              req1_rdata_q  <= oor_q ? 32'h0000_0000 : bus.mem_rdata;
            end else begin
              req0_rvalid_q <= 1'b1;
              req0_err_q    <= oor_q;
              req0_rdata_q  <= oor_q ? 32'h0000_0000 : bus.mem_rdata;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q       <= IDLE;
          req0_gnt_q    <= 1'b0;
          req1_gnt_q    <= 1'b0;
          req0_rvalid_q <= 1'b0;
          req1_rvalid_q <= 1'b0;
          req0_err_q    <= 1'b0;
          req1_err_q    <= 1'b0;
          mem_ren_q     <= 1'b0;
          mem_wen_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_gnt    = req0_gnt_q;
  assign bus.req1_gnt    = req1_gnt_q;
  assign bus.req0_rvalid = req0_rvalid_q;
  assign bus.req1_rvalid = req1_rvalid_q;
  assign bus.req0_err    = req0_err_q;
  assign bus.req1_err    = req1_err_q;
  assign bus.req0_rdata  = req0_rdata_q;
  assign bus.req1_rdata  = req1_rdata_q;
  assign bus.mem_wen     = mem_wen_q;
  assign bus.mem_ren     = mem_ren_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter: a round-robin instance drives a memory model, and a fixed-priority instance is used for the priority check.
module tb_main_memory_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  main_memory_arbiter_if bus ();
  main_memory_arbiter_if fpb ();

  main_memory_arbiter #(.MEMORY_SIZE(32'h0000_0083), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  main_memory_arbiter #(.MEMORY_SIZE(32'h0000_0083), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(fpb));

  logic [31:0] mem [0:130] = '{5: 32'hDEADBEEF, 130: 32'hCAFEF00D, default: 32'h0000_0000};

  // Memory port A model: the command is sampled on the negedge inside ISSUE
  always @(negedge clk) begin
    if (bus.mem_ren && bus.mem_addr < 32'd131) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    if (bus.mem_wen && bus.mem_addr < 32'd131) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  // Read-only view of the same memory for the fixed-priority instance
  always @(negedge clk) begin
    if (fpb.mem_ren && fpb.mem_addr < 32'd131) fpb.mem_rdata <= mem[fpb.mem_addr[7:0]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic drive0(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.req0_req = r; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
  endtask

  task automatic drive1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.req1_req = r; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
  endtask

  task automatic test_reset();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    fpb.req0_req = 1'b0; fpb.req0_we = 1'b0; fpb.req0_addr = 32'h0; fpb.req0_wdata = 32'h0;
    fpb.req1_req = 1'b0; fpb.req1_we = 1'b0; fpb.req1_addr = 32'h0; fpb.req1_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.req0_gnt, bus.req1_gnt, bus.req0_rvalid, bus.req1_rvalid, bus.req0_err, bus.req1_err, bus.mem_wen, bus.mem_ren} !== 8'h00) begin errors++; $display("FAIL reset_flags: got %b expected 00000000", {bus.req0_gnt, bus.req1_gnt, bus.req0_rvalid, bus.req1_rvalid, bus.req0_err, bus.req1_err, bus.mem_wen, bus.mem_ren}); end
    checks++; if ({bus.req0_rdata, bus.req1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {bus.req0_rdata, bus.req1_rdata}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_bus: got %h expected 0", {bus.mem_addr, bus.mem_wdata}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    drive0(1'b1, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    checks++; if ({bus.req0_gnt, bus.req1_gnt, bus.mem_ren, bus.mem_wen} !== 4'b1010) begin errors++; $display("FAIL rd_issue: got gnt0,gnt1,ren,wen=%b expected 1010", {bus.req0_gnt, bus.req1_gnt, bus.mem_ren, bus.mem_wen}); end
    checks++; if (bus.mem_addr !== 32'd5) begin errors++; $display("FAIL rd_addr: got %h expected 5", bus.mem_addr); end
    drive0(1'b0, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    checks++; if ({bus.req0_rvalid, bus.req0_err, bus.req1_rvalid, bus.req0_gnt} !== 4'b1000) begin errors++; $display("FAIL rd_resp: got rv0,err0,rv1,gnt0=%b expected 1000", {bus.req0_rvalid, bus.req0_err, bus.req1_rvalid, bus.req0_gnt}); end
    checks++; if (bus.req0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", bus.req0_rdata); end
    @(negedge clk);
    checks++; if (bus.req0_rvalid !== 1'b0 || bus.req0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got rv0=%b rdata=%h expected 0 deadbeef", bus.req0_rvalid, bus.req0_rdata); end
  endtask

  task automatic test_write_read();
    drive1(1'b1, 1'b1, 32'h10, 32'h12345678);
    @(negedge clk);
    checks++; if ({bus.req1_gnt, bus.req0_gnt, bus.mem_wen, bus.mem_ren} !== 4'b1010) begin errors++; $display("FAIL wr_issue: got gnt1,gnt0,wen,ren=%b expected 1010", {bus.req1_gnt, bus.req0_gnt, bus.mem_wen, bus.mem_ren}); end
    drive1(1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if ({bus.req1_rvalid, bus.req0_rvalid, bus.mem_wen} !== 3'b000) begin errors++; $display("FAIL wr_noresp: got rv1,rv0,wen=%b expected 000", {bus.req1_rvalid, bus.req0_rvalid, bus.mem_wen}); end
    checks++; if (mem[16] !== 32'h12345678) begin errors++; $display("FAIL wr_mem: got %h expected 12345678", mem[16]); end
    drive1(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if (bus.req1_gnt !== 1'b1 || bus.mem_ren !== 1'b1) begin errors++; $display("FAIL rd1_issue: got gnt1=%b ren=%b expected 1 1", bus.req1_gnt, bus.mem_ren); end
    drive1(1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if (bus.req1_rvalid !== 1'b1 || bus.req0_rvalid !== 1'b0 || bus.req1_rdata !== 32'h12345678) begin errors++; $display("FAIL rd1_resp: got rv1=%b rv0=%b rdata1=%h expected 1 0 12345678", bus.req1_rvalid, bus.req0_rvalid, bus.req1_rdata); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    drive0(1'b1, 1'b0, 32'd5, 32'h0);
    drive1(1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({bus.req0_gnt, bus.req1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_gnt%0d: got gnt0,gnt1=%b expected %b", k, {bus.req0_gnt, bus.req1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      @(negedge clk);
      checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_rvalid%0d: got rv0,rv1=%b expected %b", k, {bus.req0_rvalid, bus.req1_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      checks++; if (((k % 2 == 0) ? bus.req0_rdata : bus.req1_rdata) !== ((k % 2 == 0) ? 32'hDEADBEEF : 32'h12345678)) begin errors++; $display("FAIL rr_rdata%0d: got %h/%h", k, bus.req0_rdata, bus.req1_rdata); end
    end
    drive0(1'b0, 1'b0, 32'd0, 32'h0);
    drive1(1'b0, 1'b0, 32'd0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    fpb.req0_req = 1'b1; fpb.req0_we = 1'b0; fpb.req0_addr = 32'd5;
    fpb.req1_req = 1'b1; fpb.req1_we = 1'b0; fpb.req1_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({fpb.req0_gnt, fpb.req1_gnt} !== 2'b10) begin errors++; $display("FAIL fp_gnt%0d: got gnt0,gnt1=%b expected 10", k, {fpb.req0_gnt, fpb.req1_gnt}); end
      @(negedge clk);
      checks++; if ({fpb.req0_rvalid, fpb.req1_rvalid} !== 2'b10) begin errors++; $display("FAIL fp_rvalid%0d: got rv0,rv1=%b expected 10", k, {fpb.req0_rvalid, fpb.req1_rvalid}); end
    end
    fpb.req0_req = 1'b0;
    @(negedge clk);
    checks++; if ({fpb.req0_gnt, fpb.req1_gnt} !== 2'b01) begin errors++; $display("FAIL fp_gnt1: got gnt0,gnt1=%b expected 01", {fpb.req0_gnt, fpb.req1_gnt}); end
    fpb.req1_req = 1'b0;
    @(negedge clk);
    checks++; if (fpb.req1_rvalid !== 1'b1 || fpb.req1_rdata !== 32'h12345678) begin errors++; $display("FAIL fp_rd1: got rv1=%b rdata1=%h expected 1 12345678", fpb.req1_rvalid, fpb.req1_rdata); end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [3] = '{32'h0000_0083, 32'hFFFF_FFFF, 32'h0000_0082};
    logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      drive0(1'b1, wes[k], addrs[k], 32'hA5A5A5A5);
      @(negedge clk);
      checks++; if ({bus.req0_gnt, bus.mem_ren, bus.mem_wen} !== ((k == 2) ? 3'b110 : 3'b100)) begin errors++; $display("FAIL oor_issue%0d: got gnt0,ren,wen=%b expected %b", k, {bus.req0_gnt, bus.mem_ren, bus.mem_wen}, (k == 2) ? 3'b110 : 3'b100); end
      drive0(1'b0, 1'b0, 32'd0, 32'h0);
      @(negedge clk);
      checks++; if ({bus.req0_rvalid, bus.req0_err} !== ((k == 2) ? 2'b10 : 2'b11)) begin errors++; $display("FAIL oor_resp%0d: got rv0,err0=%b expected %b", k, {bus.req0_rvalid, bus.req0_err}, (k == 2) ? 2'b10 : 2'b11); end
      checks++; if (bus.req0_rdata !== ((k == 2) ? 32'hCAFEF00D : 32'h0000_0000)) begin errors++; $display("FAIL oor_rdata%0d: got %h expected %h", k, bus.req0_rdata, (k == 2) ? 32'hCAFEF00D : 32'h0000_0000); end
      @(negedge clk);
    end
    checks++; if (mem[5] !== 32'hDEADBEEF || mem[16] !== 32'h12345678 || mem[130] !== 32'hCAFEF00D) begin errors++; $display("FAIL oor_mem: got %h %h %h expected deadbeef 12345678 cafef00d", mem[5], mem[16], mem[130]); end
  endtask

  task automatic test_reset_mid_read();
    drive0(1'b1, 1'b0, 32'd5, 32'h0);
    @(posedge clk);
    #1;
    checks++; if (bus.req0_gnt !== 1'b1 || bus.mem_ren !== 1'b1) begin errors++; $display("FAIL rst_pre: got gnt0=%b ren=%b expected 1 1", bus.req0_gnt, bus.mem_ren); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.req0_gnt !== 1'b0 || bus.mem_ren !== 1'b0) begin errors++; $display("FAIL rst_async: got gnt0=%b ren=%b expected 0 0", bus.req0_gnt, bus.mem_ren); end
    drive0(1'b0, 1'b0, 32'd0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.req0_rvalid !== 1'b0 || bus.req0_gnt !== 1'b0) begin errors++; $display("FAIL rst_norv%0d: got rv0=%b gnt0=%b expected 0 0", k, bus.req0_rvalid, bus.req0_gnt); end
    end
    drive0(1'b1, 1'b0, 32'd5, 32'h0);
    drive1(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if ({bus.req0_gnt, bus.req1_gnt} !== 2'b10) begin errors++; $display("FAIL rst_first: got gnt0,gnt1=%b expected 10", {bus.req0_gnt, bus.req1_gnt}); end
    drive0(1'b0, 1'b0, 32'd0, 32'h0);
    drive1(1'b0, 1'b0, 32'd0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_fixed_prio();
    test_out_of_range();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/main_memory_arbiter.md
# main_memory_arbiter

Arbitrates main-memory port A (32-bit word read/write port) between two requesters: requester 0 is the MIC-1 datapath (MAR/MDR path), requester 1 is the program loader/debug port. It holds each requester with a req/gnt handshake and issues one registered single-cycle command to the memory. It returns read data with a one-cycle rvalid pulse and rejects out-of-range addresses without touching memory. It sits between the datapath/loader and main_memory port A; port B (instruction byte fetch) is not routed through it.

## Interface
- MEMORY_SIZE, 'h0083: number of 32-bit words in main memory; valid word addresses are 0..MEMORY_SIZE-1.
- FIXED_PRIO, 0: 0 = round-robin; 1 = requester 0 always wins contention.

- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_req, req1_req  in  1  request valid; held high and stable until gnt.
- req0_we, req1_we  in  1  1 = write, 0 = read.
- req0_addr, req1_addr  in  32  word address.
- req0_wdata, req1_wdata  in  32  write data.
- req0_gnt, req1_gnt  out  1  one-cycle pulse: request accepted.
- req0_rvalid, req1_rvalid  out  1  one-cycle pulse: response (read data or error) valid.
- req0_rdata, req1_rdata  out  32  read data; valid only with rvalid.
- req0_err, req1_err  out  1  qualifies rvalid: address out of range.
- mem_wen, mem_ren  out  1  to main memory port A enables.
- mem_addr, mem_wdata  out  32  to main memory port A.
- mem_rdata  in  32  from main memory port A.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- Arbitration happens only at a posedge leaving IDLE or RESP. If any req is high, register the winner's we/addr/wdata and go to ISSUE; otherwise go to IDLE.
- Round-robin: pointer last_gnt; on contention the requester not granted last wins; pointer updates on every grant. Reset value makes requester 0 win first contention. FIXED_PRIO=1 ignores the pointer.
- ISSUE (exactly one cycle): gnt of winner high; for an in-range address (addr < MEMORY_SIZE) mem_ren=!we or mem_wen=we; out-of-range: both enables 0.
- ISSUE exit: read or out-of-range → RESP; in-range write → IDLE (no response).
- RESP (one cycle): winner's rvalid=1, rdata = mem_rdata captured at the ISSUE→RESP edge; out-of-range: rdata=0, err=1 (also for writes).
- Non-winning rdata/rvalid/err unchanged/0. rdata holds last value between responses.
- A req still high at the edge after gnt is treated as a new request.
- mem_addr/mem_wdata hold last issued values outside ISSUE; enables are 0 outside ISSUE.

## Timing
- All outputs registered; none combinationally depend on req inputs.
- Reset values: state IDLE, all gnt/rvalid/err/mem_wen/mem_ren 0, rdata 0, mem_addr 0, mem_wdata 0, last_gnt=1.
- Read latency: req high at edge N → gnt in cycle N+1 (ISSUE) → rvalid in cycle N+2. Memory samples command on the negedge inside ISSUE; mem_rdata is stable by the ISSUE→RESP posedge.
- Throughput: one read per 2 cycles (ISSUE,RESP,ISSUE,...); one write per 2 cycles (ISSUE,IDLE,ISSUE).
- Simultaneous requests: one grant only; loser's request stays pending and wins the next arbitration (round-robin).
- Reset mid-operation: rst_n low clears outputs immediately (async); in-flight read yields no rvalid; a write whose ISSUE negedge has not yet occurred is dropped.
- Address compare is unsigned 32-bit; 'hFFFFFFFF is out of range.

## Test plan
- Single read: memory word 5 = 'hDEADBEEF; req0 read addr 5 at cycle 0 → req0_gnt cycle 1, mem_ren=1 cycle 1, req0_rvalid=1 and req0_rdata='hDEADBEEF cycle 2, err=0.
- Write then read: req1 write addr 'h10 data 'h12345678 → gnt, mem_wen one cycle, no rvalid; subsequent req1 read 'h10 → rdata 'h12345678.
- Contention round-robin: both requesters hold reads continuously → grants alternate 0,1,0,1 every 2 cycles, each rvalid on its own port only; FIXED_PRIO=1 → only requester 0 granted while it holds req.
- Out of range: req0 read addr 'h0083 and write addr 'hFFFFFFFF → gnt, mem_ren=mem_wen=0, rvalid=1 with err=1, rdata=0; memory contents unchanged.
- Reset mid-read: assert rst_n low during ISSUE of a req0 read → gnt/mem_ren drop immediately, no rvalid after release, first post-reset contention granted to requester 0.
